// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: FSM state encoding, instruction
// field positions and the ALU opcode map (SEL) it drives.
package alu_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  // Instruction word: [7]=halt, [6:4]=ALU select, [3:0]=immediate
  localparam int HALT_BIT = 7;
  localparam int SEL_HI   = 6;
  localparam int SEL_LO   = 4;
  localparam int IMM_HI   = 3;
  localparam int IMM_LO   = 0;

  // ALU opcodes; 3'b111 has no name here but is still passed through
  localparam logic [2:0] SEL_AND  = 3'b000;
  localparam logic [2:0] SEL_OR   = 3'b001;
  localparam logic [2:0] SEL_ADD  = 3'b010;
  localparam logic [2:0] SEL_ANDN = 3'b011;
  localparam logic [2:0] SEL_ORN  = 3'b100;
  localparam logic [2:0] SEL_SUB  = 3'b101;
  localparam logic [2:0] SEL_SLT  = 3'b110;

endpackage

// File: rtl/alu_sequencer_pc_counter.sv
// pc_counter: loadable, enabled, wrapping program counter.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset (q -> 0)
//   en          - low freezes q
//   ld, ld_val  - load q from ld_val (beats inc)
//   inc         - q <= q + 1, wrapping modulo 2^W
//   q           - current count
module pc_counter #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n)      q <= '0;
    else if (en) begin
      if (ld)        q <= ld_val;
      else if (inc)  q <= q + W'(1);
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/decode/exec controller and accumulator in front of the
// 4-bit combinational ALU. Each non-halt instruction takes FETCH, DECODE,
// EXEC (3 cycles); the ALU result is written back to acc in EXEC.
// Ports:
//   clk, rst_n       - clock, synchronous active-low reset
//   en               - global enable, low freezes all state
//   start            - level; run from IDLE or resume from HALT
//   load, load_addr  - load pc in IDLE/HALT (beats start)
//   rom_addr         - ROM address (= pc); rom_data valid one cycle later
//   alu_a/b/sel      - ALU operands/opcode: acc, ir immediate, ir select
//   alu_out          - ALU result
//   acc, zero        - accumulator and its registered zero flag
//   busy, done       - in FETCH/DECODE/EXEC, in HALT
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int PC_W   = 12,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              start,
  input  logic              load,
  input  logic [PC_W-1:0]   load_addr,
  output logic [PC_W-1:0]   rom_addr,
  input  logic [7:0]        rom_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] acc,
  output logic              zero,
  output logic              busy,
  output logic              done
);

  state_t state, state_nxt;
  // The halt bit is acted on at decode and never needed again, so ir
  // keeps only the select and immediate fields.
  logic [SEL_HI:0] ir;
  logic pc_ld, pc_inc, ir_we, acc_we;

  pc_counter #(.W(PC_W)) u_pc (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .ld     (pc_ld),
    .ld_val (load_addr),
    .inc    (pc_inc),
    .q      (rom_addr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ir    <= '0;
      acc   <= '0;
      zero  <= 1'b1;
    end else if (en) begin
      state <= state_nxt;
      if (ir_we)  ir <= rom_data[SEL_HI:0];
      if (acc_we) begin
        acc  <= alu_out;
        zero <= (alu_out == '0);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pc_ld     = 1'b0;
    pc_inc    = 1'b0;
    ir_we     = 1'b0;
    acc_we    = 1'b0;
    case (state)
      S_IDLE, S_HALT: begin
        if (load)       pc_ld     = 1'b1;
        else if (start) state_nxt = S_FETCH;
      end
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: begin
        ir_we = 1'b1;
        if (rom_data[HALT_BIT]) begin
          // skip past the halt word so a later start resumes after it
          pc_inc    = 1'b1;
          state_nxt = S_HALT;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        acc_we    = 1'b1;
        pc_inc    = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign alu_a   = acc;
  assign alu_b   = ir[IMM_HI:IMM_LO];
  assign alu_sel = ir[SEL_HI:SEL_LO];
  assign busy    = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
  assign done    = (state == S_HALT);

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, en, start, load;
  logic [11:0] load_addr, rom_addr;
  logic [7:0]  rom_data;
  logic [3:0]  alu_a, alu_b, alu_out, acc;
  logic [2:0]  alu_sel;
  logic        zero, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] rom [0:4095];

  alu_sequencer #(.PC_W(12), .DATA_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .load(load),
    .load_addr(load_addr), .rom_addr(rom_addr), .rom_data(rom_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .acc(acc), .zero(zero), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // behavioural synchronous ROM
  always @(posedge clk) rom_data <= rom[rom_addr];

  // behavioural 4-bit ALU
  function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] s);
    case (s)
      SEL_AND:  return a & b;
      SEL_OR:   return a | b;
      SEL_ADD:  return a + b;
      SEL_ANDN: return a & ~b;
      SEL_ORN:  return a | ~b;
      SEL_SUB:  return a - b;
      SEL_SLT:  return (a < b) ? 4'd1 : 4'd0;
      default:  return 4'd0;
    endcase
  endfunction
  assign alu_out = alu_f(alu_a, alu_b, alu_sel);

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rom_fill;
    for (int i = 0; i < 4096; i++) rom[i] = 8'h80;
  endtask

  task automatic reset_dut;
    rst_n = 1'b0; start = 1'b0; load = 1'b0; en = 1'b1;
    step(1);
    rst_n = 1'b1;
  endtask

  task automatic start_pulse;
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic test_reset;
    rom_fill();
    reset_dut();
    n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL reset_busy_done got=%b exp=00", {busy, done}); end
    n_cmp++; if (rom_addr !== 12'h000) begin n_err++; $display("FAIL reset_pc got=%h exp=000", rom_addr); end
    n_cmp++; if ({alu_sel, alu_b} !== 7'd0) begin n_err++; $display("FAIL reset_ir got=%h exp=0", {alu_sel, alu_b}); end
    n_cmp++; if ({acc, zero} !== 5'b0000_1) begin n_err++; $display("FAIL reset_acc_zero got=%h exp=01", {acc, zero}); end
  endtask

  // ADD 5, ADD 3, SUB 3, HALT; then resume after the halt word
  task automatic test_program;
    rom_fill();
    rom[0] = 8'h25; rom[1] = 8'h23; rom[2] = 8'h53; rom[3] = 8'h80;
    rom[4] = 8'h21; rom[5] = 8'h80;
    reset_dut();
    start_pulse();                       // edge 1
    for (int e = 2; e <= 12; e++) begin
      step(1);
      if (e == 3) begin n_cmp++; if (acc !== 4'h0) begin n_err++; $display("FAIL prog_acc_e3 got=%h exp=0", acc); end end
      if (e == 4) begin n_cmp++; if (acc !== 4'h5) begin n_err++; $display("FAIL prog_acc_e4 got=%h exp=5", acc); end end
      if (e == 7) begin n_cmp++; if (acc !== 4'h8) begin n_err++; $display("FAIL prog_acc_e7 got=%h exp=8", acc); end end
      if (e == 10) begin n_cmp++; if (acc !== 4'h5) begin n_err++; $display("FAIL prog_acc_e10 got=%h exp=5", acc); end end
      if (e < 12) begin n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL prog_busy_e%0d got=%b exp=1", e, busy); end end
      n_cmp++; if (zero !== 1'b0 && e >= 4) begin n_err++; $display("FAIL prog_zero_e%0d got=%b exp=0", e, zero); end
    end
    n_cmp++; if ({done, busy} !== 2'b10) begin n_err++; $display("FAIL prog_halt got=%b exp=10", {done, busy}); end
    n_cmp++; if (rom_addr !== 12'h004) begin n_err++; $display("FAIL prog_halt_pc got=%h exp=004", rom_addr); end
    start_pulse(); step(3);
    n_cmp++; if (acc !== 4'h6) begin n_err++; $display("FAIL prog_resume_acc got=%h exp=6", acc); end
  endtask

  // SUB 1 from 0, AND F, AND 0
  task automatic test_sub_and;
    rom_fill();
    rom[0] = 8'h51; rom[1] = 8'h0F; rom[2] = 8'h00;
    reset_dut();
    start_pulse(); step(3);
    n_cmp++; if ({acc, zero} !== {4'hF, 1'b0}) begin n_err++; $display("FAIL sub_wrap got=%h/%b exp=f/0", acc, zero); end
    step(3);
    n_cmp++; if ({acc, zero} !== {4'hF, 1'b0}) begin n_err++; $display("FAIL and_f got=%h/%b exp=f/0", acc, zero); end
    step(3);
    n_cmp++; if ({acc, zero} !== {4'h0, 1'b1}) begin n_err++; $display("FAIL and_0 got=%h/%b exp=0/1", acc, zero); end
  endtask

  // ADD 5, SLT 9, ADD 4, SLT 3 (unsigned compare)
  task automatic test_slt;
    rom_fill();
    rom[0] = 8'h25; rom[1] = 8'h69; rom[2] = 8'h24; rom[3] = 8'h63;
    reset_dut();
    start_pulse(); step(6);
    n_cmp++; if (acc !== 4'h1) begin n_err++; $display("FAIL slt_true got=%h exp=1", acc); end
    step(6);
    n_cmp++; if ({acc, zero} !== {4'h0, 1'b1}) begin n_err++; $display("FAIL slt_false got=%h/%b exp=0/1", acc, zero); end
  endtask

  // SEL 3'b111 and immediate fields reach the ALU unmodified
  task automatic test_fields;
    rom_fill();
    rom[0] = 8'h7A;
    reset_dut();
    start_pulse(); step(2);               // now in EXEC
    n_cmp++; if ({alu_sel, alu_b, alu_a} !== {3'b111, 4'hA, 4'h0}) begin n_err++; $display("FAIL fields got=%h exp=7a0", {1'b0, alu_sel, alu_b, alu_a}); end
  endtask

  task automatic test_wrap;
    rom_fill();
    rom[12'hFFF] = 8'h21; rom[0] = 8'h80;
    reset_dut();
    load_addr = 12'hFFF; load = 1'b1; step(1); load = 1'b0;
    n_cmp++; if ({busy, rom_addr} !== {1'b0, 12'hFFF}) begin n_err++; $display("FAIL wrap_load got=%b/%h exp=0/fff", busy, rom_addr); end
    start_pulse(); step(3);
    n_cmp++; if ({acc, rom_addr} !== {4'h1, 12'h000}) begin n_err++; $display("FAIL wrap_pc got=%h/%h exp=1/000", acc, rom_addr); end
    step(2);
    n_cmp++; if ({done, rom_addr} !== {1'b1, 12'h001}) begin n_err++; $display("FAIL wrap_halt got=%b/%h exp=1/001", done, rom_addr); end
    // load beats start in HALT
    load_addr = 12'h010; load = 1'b1; start = 1'b1; step(1); load = 1'b0; start = 1'b0;
    n_cmp++; if ({done, rom_addr} !== {1'b1, 12'h010}) begin n_err++; $display("FAIL halt_load got=%b/%h exp=1/010", done, rom_addr); end
  endtask

  task automatic test_priority;
    rom_fill();
    reset_dut();
    load_addr = 12'h123; load = 1'b1; start = 1'b1; step(1); load = 1'b0; start = 1'b0;
    n_cmp++; if ({busy, done, rom_addr} !== {2'b00, 12'h123}) begin n_err++; $display("FAIL idle_load_start got=%b/%h exp=00/123", {busy, done}, rom_addr); end
    step(1);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_stay got=%b exp=0", busy); end
  endtask

  task automatic test_enable;
    rom_fill();
    rom[0] = 8'h23;
    reset_dut();
    start_pulse(); step(2);               // now in EXEC
    en = 1'b0; load = 1'b1; load_addr = 12'h0AA;
    for (int i = 0; i < 5; i++) begin
      step(1);
      n_cmp++; if ({acc, rom_addr} !== {4'h0, 12'h000}) begin n_err++; $display("FAIL en_hold_%0d got=%h/%h exp=0/000", i, acc, rom_addr); end
    end
    load = 1'b0; en = 1'b1; step(1);
    n_cmp++; if ({acc, rom_addr} !== {4'h3, 12'h001}) begin n_err++; $display("FAIL en_write got=%h/%h exp=3/001", acc, rom_addr); end
    // load while busy is ignored
    load = 1'b1; load_addr = 12'h055; step(1); load = 1'b0;
    n_cmp++; if ({acc, rom_addr} !== {4'h3, 12'h001}) begin n_err++; $display("FAIL busy_load got=%h/%h exp=3/001", acc, rom_addr); end
    step(1);
    n_cmp++; if ({done, rom_addr} !== {1'b1, 12'h002}) begin n_err++; $display("FAIL en_halt got=%b/%h exp=1/002", done, rom_addr); end
  endtask

  task automatic test_reset_mid;
    rom_fill();
    rom[0] = 8'h27;
    reset_dut();
    start_pulse(); step(2);               // now in EXEC
    n_cmp++; if (alu_out !== 4'h7) begin n_err++; $display("FAIL mid_alu got=%h exp=7", alu_out); end
    rst_n = 1'b0; step(1); rst_n = 1'b1;
    n_cmp++; if ({acc, zero, busy, done, rom_addr} !== {4'h0, 3'b100, 12'h000}) begin n_err++; $display("FAIL mid_reset got=%h/%b%b%b/%h exp=0/100/000", acc, zero, busy, done, rom_addr); end
    step(1);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_idle got=%b exp=0", busy); end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; start = 1'b0; load = 1'b0; load_addr = '0;
    test_reset();
    test_program();
    test_sub_and();
    test_slt();
    test_fields();
    test_wrap();
    test_priority();
    test_enable();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
